// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-stream input and payload/status output bundle of the UART frame controller.
interface uart_rx_frame_ctrl_if;
    logic [7:0] rx_dat;
    logic       rx_dat_en;
    logic [7:0] out_dat;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] out_addr;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] drop_cnt;

    // Frame controller side
    modport slave (
        input  rx_dat, rx_dat_en, out_ready,
        output out_dat, out_valid, out_last, out_addr,
        output frame_ok, frame_err, err_code, drop_cnt
    );

    // Byte source / payload consumer side
    modport master (
        output rx_dat, rx_dat_en, out_ready,
        input  out_dat, out_valid, out_last, out_addr,
        input  frame_ok, frame_err, err_code, drop_cnt
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Parses SYNC/ADDR/LEN/payload/CHK frames from the UART byte stream, buffers the
// payload and releases it over valid/ready only once length and XOR checksum pass.
module uart_rx_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 17340
) (
    input logic                  clk,
    input logic                  reset,
    uart_rx_frame_ctrl_if.slave  bus
);

    localparam int unsigned IW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned CW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] MAX_LEN_B   = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_LEN, GET_DATA, GET_CHK, DRAIN
    } state_t;

    state_t        state, state_d;
    logic [7:0]    addr, addr_d, len, len_d, chk, chk_d;
    logic [IW-1:0] idx, idx_d, idx_inc;
    logic [CW-1:0] cnt, cnt_d;
    logic          in_frame, buf_we;
    logic [7:0]    pay_mem [MAX_LEN];

    logic [7:0] out_dat_q, out_dat_d, out_addr_q, out_addr_d, drop_cnt_q, drop_cnt_d;
    logic       out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic       frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
    logic [1:0] err_code_q, err_code_d;

    assign in_frame = (state == GET_ADDR) || (state == GET_LEN) ||
                      (state == GET_DATA) || (state == GET_CHK);
    assign idx_inc  = IW'(idx + IW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d     = state;
        addr_d      = addr;
        len_d       = len;
        chk_d       = chk;
        idx_d       = idx;
        cnt_d       = cnt;
        buf_we      = 1'b0;
        out_dat_d   = out_dat_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_addr_d  = out_addr_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        drop_cnt_d  = drop_cnt_q;

        // Every state change into or within the frame happens on an accepted byte,
        // so reloading on any byte also covers the reload-on-entry case.
        if (bus.rx_dat_en)               cnt_d = CNT_LOAD;
        else if (in_frame && cnt != '0)  cnt_d = cnt - CW'(1);

        case (state)
            IDLE: begin
                if (bus.rx_dat_en && bus.rx_dat == SYNC_BYTE) state_d = GET_ADDR;
            end
            GET_ADDR: begin
                if (bus.rx_dat_en) begin
                    addr_d  = bus.rx_dat;
                    chk_d   = bus.rx_dat;
                    state_d = GET_LEN;
                end
            end
            GET_LEN: begin
                if (bus.rx_dat_en) begin
                    if (bus.rx_dat == 8'd0 || bus.rx_dat > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd1;
                        state_d     = IDLE;
                    end else begin
                        len_d   = bus.rx_dat;
                        chk_d   = chk ^ bus.rx_dat;
                        idx_d   = '0;
                        state_d = GET_DATA;
                    end
                end
            end
            GET_DATA: begin
                if (bus.rx_dat_en) begin
                    buf_we = 1'b1;
                    chk_d  = chk ^ bus.rx_dat;
                    if (8'(idx) == len - 8'd1) state_d = GET_CHK;
                    else                       idx_d   = idx_inc;
                end
            end
            GET_CHK: begin
                if (bus.rx_dat_en) begin
                    if (bus.rx_dat == chk) begin
                        frame_ok_d  = 1'b1;
                        out_addr_d  = addr;
                        idx_d       = '0;
                        out_dat_d   = pay_mem[0];
                        out_valid_d = 1'b1;
                        out_last_d  = (len == 8'd1);
                        state_d     = DRAIN;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd2;
                        state_d     = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (bus.rx_dat_en && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        idx_d      = idx_inc;
                        out_dat_d  = pay_mem[idx_inc];
                        out_last_d = (8'(idx) + 8'd1 == len - 8'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Inter-byte timeout; a byte arriving on the expiry cycle takes precedence
        if (in_frame && !bus.rx_dat_en && cnt == '0) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd3;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr        <= '0;
            len         <= '0;
            chk         <= '0;
            idx         <= '0;
            cnt         <= '0;
            out_dat_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_addr_q  <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            addr        <= addr_d;
            len         <= len_d;
            chk         <= chk_d;
            idx         <= idx_d;
            cnt         <= cnt_d;
            out_dat_q   <= out_dat_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_addr_q  <= out_addr_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Payload buffer needs no reset; contents are only read after a full frame
    always_ff @(posedge clk) begin
        if (buf_we) pay_mem[idx] <= bus.rx_dat;
    end

    assign bus.out_dat   = out_dat_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_code  = err_code_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: good/bad frames, length limits, timeout,
// backpressure, dropped bytes and reset mid-frame.
module tb_uart_rx_frame_ctrl;

    localparam int unsigned TIMEOUT_CYC = 17340;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [7:0] pay_q [$];
    logic [7:0] exp_q [$];

    uart_rx_frame_ctrl_if bus_if ();

    uart_rx_frame_ctrl #(
        .SYNC_BYTE  (8'hA5),
        .MAX_LEN    (16),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.rx_dat    = b;
        bus_if.rx_dat_en = 1'b1;
        tick();
        bus_if.rx_dat_en = 1'b0;
    endtask

    // SYNC, ADDR, LEN, pay_q contents, then the given CHK byte
    task automatic send_frame(input logic [7:0] a, input logic [7:0] l, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(l);
        foreach (pay_q[k]) send_byte(pay_q[k]);
        send_byte(c);
    endtask

    function automatic logic [7:0] calc_chk(input logic [7:0] a, input logic [7:0] l);
        logic [7:0] c;
        c = a ^ l;
        foreach (pay_q[k]) c ^= pay_q[k];
        return c;
    endfunction

    // Drains exp_q; mode 0 = always ready, mode 1 = random backpressure
    task automatic drain(input int mode, input bit chk_ok, input logic [7:0] exp_addr);
        int   i;
        int   guard;
        logic rdy;
        i = 0;
        guard = 0;
        if (chk_ok) check("frame_ok_pulse", 32'(bus_if.frame_ok), 32'd1);
        check("frame_err_quiet", 32'(bus_if.frame_err), 32'd0);
        check("out_addr", 32'(bus_if.out_addr), 32'(exp_addr));
        while (i < exp_q.size() && guard < 500) begin
            rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus_if.out_ready = rdy;
            if (chk_ok && guard == 1) check("frame_ok_one_cycle", 32'(bus_if.frame_ok), 32'd0);
            check("out_valid_hold", 32'(bus_if.out_valid), 32'd1);
            if (bus_if.out_valid) begin
                check("out_dat", 32'(bus_if.out_dat), 32'(exp_q[i]));
                check("out_last", 32'(bus_if.out_last), 32'(i == exp_q.size() - 1));
                if (rdy) i++;
            end
            tick();
            guard++;
        end
        bus_if.out_ready = 1'b0;
        check("drain_count", 32'(i), 32'(exp_q.size()));
        check("out_valid_off", 32'(bus_if.out_valid), 32'd0);
    endtask

    initial begin
        int         k;
        logic [7:0] c;
        checks   = 0;
        failures = 0;
        bus_if.rx_dat    = 8'h00;
        bus_if.rx_dat_en = 1'b0;
        bus_if.out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_frame_ok", 32'(bus_if.frame_ok), 32'd0);
        check("rst_frame_err", 32'(bus_if.frame_err), 32'd0);
        check("rst_err_code", 32'(bus_if.err_code), 32'd0);
        check("rst_drop_cnt", 32'(bus_if.drop_cnt), 32'd0);
        reset = 1'b0;
        tick();

        // Garbage before SYNC is ignored
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        check("garbage_no_err", 32'(bus_if.frame_err), 32'd0);

        // Good frame A5 03 02 11 22 32
        pay_q = '{8'h11, 8'h22};
        exp_q = '{8'h11, 8'h22};
        send_frame(8'h03, 8'h02, 8'h32);
        drain(0, 1'b1, 8'h03);

        // Same frame with CHK=33
        send_frame(8'h03, 8'h02, 8'h33);
        check("badchk_err", 32'(bus_if.frame_err), 32'd1);
        check("badchk_code", 32'(bus_if.err_code), 32'd2);
        check("badchk_no_valid", 32'(bus_if.out_valid), 32'd0);
        check("badchk_no_ok", 32'(bus_if.frame_ok), 32'd0);
        tick();
        check("badchk_err_one_cycle", 32'(bus_if.frame_err), 32'd0);
        check("badchk_code_held", 32'(bus_if.err_code), 32'd2);

        // A5 01 01 7E 7E
        pay_q = '{8'h7E};
        exp_q = '{8'h7E};
        send_frame(8'h01, 8'h01, 8'h7E);
        drain(0, 1'b1, 8'h01);

        // LEN limits
        send_byte(8'hA5);
        send_byte(8'h07);
        send_byte(8'h00);
        check("len0_err", 32'(bus_if.frame_err), 32'd1);
        check("len0_code", 32'(bus_if.err_code), 32'd1);
        send_byte(8'hA5);
        send_byte(8'h07);
        send_byte(8'h11);
        check("len17_err", 32'(bus_if.frame_err), 32'd1);
        check("len17_code", 32'(bus_if.err_code), 32'd1);

        // LEN=16 under random backpressure
        pay_q.delete();
        for (int j = 0; j < 16; j++) pay_q.push_back(8'h30 + 8'(j * 7));
        exp_q = pay_q;
        c = calc_chk(8'h44, 8'd16);
        send_frame(8'h44, 8'd16, c);
        drain(1, 1'b1, 8'h44);

        // Timeout after A5 05
        send_byte(8'hA5);
        send_byte(8'h05);
        k = 0;
        while (!bus_if.frame_err && k < TIMEOUT_CYC + 10) begin
            tick();
            k++;
        end
        check("timeout_latency", 32'(k), 32'(TIMEOUT_CYC));
        check("timeout_code", 32'(bus_if.err_code), 32'd3);

        // Byte on the expiry cycle wins: A5 05 02 AA BB 16
        send_byte(8'hA5);
        send_byte(8'h05);
        repeat (TIMEOUT_CYC - 1) tick();
        check("pre_expiry_quiet", 32'(bus_if.frame_err), 32'd0);
        send_byte(8'h02);
        check("expiry_byte_no_err", 32'(bus_if.frame_err), 32'd0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'h16);
        exp_q = '{8'hAA, 8'hBB};
        drain(0, 1'b1, 8'h05);

        // Three bytes dropped while stalled in DRAIN: A5 09 03 01 02 03 0A
        pay_q = '{8'h01, 8'h02, 8'h03};
        exp_q = pay_q;
        send_frame(8'h09, 8'h03, 8'h0A);
        check("drop_frame_ok", 32'(bus_if.frame_ok), 32'd1);
        send_byte(8'h55);
        send_byte(8'hA5);
        send_byte(8'h66);
        check("drop_cnt_3", 32'(bus_if.drop_cnt), 32'd3);
        check("stall_dat_stable", 32'(bus_if.out_dat), 32'h01);
        drain(0, 1'b0, 8'h09);

        // 300 drops saturate: A5 0A 01 5A 51
        pay_q = '{8'h5A};
        exp_q = pay_q;
        send_frame(8'h0A, 8'h01, 8'h51);
        check("sat_frame_ok", 32'(bus_if.frame_ok), 32'd1);
        repeat (300) send_byte(8'h00);
        check("drop_cnt_sat", 32'(bus_if.drop_cnt), 32'd255);
        drain(0, 1'b0, 8'h0A);

        // Reset asserted mid GET_DATA
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h04);
        send_byte(8'h11);
        send_byte(8'h22);
        reset = 1'b1;
        #2;
        check("async_rst_addr", 32'(bus_if.out_addr), 32'd0);
        check("async_rst_drop", 32'(bus_if.drop_cnt), 32'd0);
        check("async_rst_code", 32'(bus_if.err_code), 32'd0);
        check("async_rst_pulses", 32'({bus_if.frame_ok, bus_if.frame_err}), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_no_err", 32'(bus_if.frame_err), 32'd0);
        pay_q = '{8'h99};
        exp_q = pay_q;
        send_frame(8'h0C, 8'h01, 8'h94);
        drain(0, 1'b1, 8'h0C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
